hybrid_control_pipe: RTL and testbench

Parametrised, pipelined successor to the quarter-plane hybrid switching controller of the resonant-converter loop. Takes signed ADC samples of capacitor voltage and current, applies the sigma-dependent coordinate transform and rotation by a precomputed sin/cos pair, and toggles the switching variable sigma when the state enters the jump set. It adds widths, gains and dwell as parameters, a quarter-plane or half-plane jump-set mode, a sample-valid handshake, a minimum-dwell lockout, and pipeline flush on every switch. It sits between the ADC interface and the gate-drive/dead-time logic.

---
 rtl/hybrid_pkg.sv | 22 ++
 rtl/hybrid_dwell_timer.sv | 62 ++++++
 rtl/hybrid_control_pipe.sv | 152 +++++++++++++++
 tb/tb_hybrid_control_pipe.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/hybrid_pkg.sv
// Shared widths, Q-format helper, mode encodings and dwell FSM states for the
// hybrid switching controller.
package hybrid_pkg;

    localparam int DATA_W_DEF = 14;
    localparam int COEF_W_DEF = 16;
    localparam int Z_W_DEF    = 32;

    localparam logic MODE_QUARTER = 1'b0;
    localparam logic MODE_HALF    = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } dwell_state_e;

    // Value of 1.0 in the signed Q2.(coef_w-2) sin/cos format.
    function automatic int q_one(input int coef_w);
        return 32'sd1 <<< (coef_w - 2);
    endfunction

endpackage

// File: rtl/hybrid_dwell_timer.sv
// Minimum-dwell lockout: loads MIN_DWELL-1 on a toggle and counts down to zero;
// LOCK is held exactly while the counter is non-zero.
module hybrid_dwell_timer
    import hybrid_pkg::*;
#(
    parameter int MIN_DWELL = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic busy_o
);

    localparam int CNT_W = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MIN_DWELL - 1);

    dwell_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A MIN_DWELL of 1 loads zero, so the timer never leaves IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (load_i && (LOAD_VAL != '0)) begin
                    cnt_d   = LOAD_VAL;
                    state_d = ST_LOCK;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = ST_LOCK;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o = (state_q == ST_LOCK);

endmodule

// File: rtl/hybrid_control_pipe.sv
// Three-stage hybrid switching controller: sigma-dependent transform, rotation
// by sin/cos, jump-set decision with dwell lockout and pipeline flush on toggle.
module hybrid_control_pipe
    import hybrid_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int COEF_W    = COEF_W_DEF,
    parameter int MU_Z1     = 110,
    parameter int MU_Z2     = 25,
    parameter int VG        = 24000,
    parameter int MIN_DWELL = 16,
    parameter int Z_W       = Z_W_DEF
) (
    input  logic              i_clock,
    input  logic              i_RESET,
    input  logic              i_enable,
    input  logic              i_mode,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_vC,
    input  logic [DATA_W-1:0] i_iC,
    input  logic [COEF_W-1:0] i_cos,
    input  logic [COEF_W-1:0] i_sin,
    output logic              o_sigma,
    output logic              o_switch,
    output logic              o_valid,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_debug
);

    localparam int PROD_W = Z_W + COEF_W;
    localparam int ACC_W  = PROD_W + 1;

    localparam logic signed [Z_W-1:0]  MU1_C   = Z_W'(MU_Z1);
    localparam logic signed [Z_W-1:0]  MU2_C   = Z_W'(MU_Z2);
    localparam logic signed [Z_W-1:0]  VG_C    = Z_W'(VG);
    localparam logic [DATA_W-1:0]      DBG_OFS = DATA_W'((1 << (DATA_W - 1)) - 1);

    logic                     v1_q, v2_q, v3_q, v2_d, v3_d;
    logic                     sigma_q, sigma_d, switch_q, toggle_s, busy_s, jump_cond_s;
    logic                     neg1_q, neg2_q;
    logic signed [Z_W-1:0]    vc_ext_s, ic_ext_s, z1_d, z2_d, z1_q, z2_q;
    logic signed [COEF_W-1:0] sin1_q, cos1_q;
    logic signed [PROD_W-1:0] p_zs_d, p_zc_d, p_z1c_d, p_z2s_d;
    logic signed [PROD_W-1:0] p_zs_q, p_zc_q, p_z1c_q, p_z2s_q;
    logic signed [ACC_W-1:0]  sum1_s, sum2_s, j1_d, j2_d, j1_q, j2_q;
    logic [DATA_W-1:0]        debug_d, debug_q;

    assign vc_ext_s = Z_W'($signed(i_vC));
    assign ic_ext_s = Z_W'($signed(i_iC));

    // Stage-1 sign follows the sigma that will be in force after this edge, so a
    // sample arriving in a toggle cycle already sees the new sigma.
    always_comb begin
        z1_d = vc_ext_s * MU1_C;
        z2_d = ic_ext_s * MU2_C;
        if (sigma_d) begin
            z1_d = z1_d - VG_C;
        end else begin
            z1_d = z1_d + VG_C;
        end
    end

    assign p_zs_d  = PROD_W'(z1_q) * PROD_W'(sin1_q);
    assign p_zc_d  = PROD_W'(z2_q) * PROD_W'(cos1_q);
    assign p_z1c_d = PROD_W'(z1_q) * PROD_W'(cos1_q);
    assign p_z2s_d = PROD_W'(z2_q) * PROD_W'(sin1_q);

    always_comb begin
        sum1_s = ACC_W'(p_zs_q) + ACC_W'(p_zc_q);
        sum2_s = ACC_W'(p_z2s_q) - ACC_W'(p_z1c_q);
        if (neg2_q) begin
            j1_d = -sum1_s;
            j2_d = -sum2_s;
        end else begin
            j1_d = sum1_s;
            j2_d = sum2_s;
        end
    end

    assign debug_d     = j1_d[ACC_W-1 -: DATA_W] + DBG_OFS;
    assign jump_cond_s = j1_q[ACC_W-1] && ((i_mode == MODE_HALF) || j2_q[ACC_W-1]);
    assign toggle_s    = v3_q && jump_cond_s && i_enable && !busy_s;
    assign sigma_d     = sigma_q ^ toggle_s;
    assign v2_d        = v1_q && !toggle_s;
    assign v3_d        = v2_q && !toggle_s;

    always_ff @(posedge i_clock) begin
        if (i_RESET) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            sigma_q  <= 1'b1;
            switch_q <= 1'b0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            z1_q     <= '0;
            z2_q     <= '0;
            sin1_q   <= '0;
            cos1_q   <= '0;
            p_zs_q   <= '0;
            p_zc_q   <= '0;
            p_z1c_q  <= '0;
            p_z2s_q  <= '0;
            j1_q     <= '0;
            j2_q     <= '0;
            debug_q  <= '0;
        end else begin
            v1_q     <= i_valid;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            sigma_q  <= sigma_d;
            switch_q <= toggle_s;
            if (i_valid) begin
                z1_q   <= z1_d;
                z2_q   <= z2_d;
                sin1_q <= i_sin;
                cos1_q <= i_cos;
                neg1_q <= sigma_d;
            end
            if (v1_q) begin
                p_zs_q  <= p_zs_d;
                p_zc_q  <= p_zc_d;
                p_z1c_q <= p_z1c_d;
                p_z2s_q <= p_z2s_d;
                neg2_q  <= neg1_q;
            end
            if (v2_q) begin
                j1_q <= j1_d;
                j2_q <= j2_d;
            end
            if (v3_d) begin
                debug_q <= debug_d;
            end
        end
    end

    hybrid_dwell_timer #(
        .MIN_DWELL(MIN_DWELL)
    ) u_dwell (
        .clk_i (i_clock),
        .rst_i (i_RESET),
        .load_i(toggle_s),
        .busy_o(busy_s)
    );

    assign o_sigma  = sigma_q;
    assign o_switch = switch_q;
    assign o_valid  = v3_q;
    assign o_busy   = busy_s;
    assign o_debug  = debug_q;

endmodule

// File: tb/tb_hybrid_control_pipe.sv
// Scoreboard bench for hybrid_control_pipe: stimulus pushes hand-computed
// decision results, a negedge monitor pops and checks them.
module tb_hybrid_control_pipe;

    typedef struct packed {
        logic [13:0] dbg;
        logic        sw;
        logic        sig;
    } exp_t;

    localparam logic [13:0] DBG_NEG = 14'd8190;
    localparam logic [13:0] DBG_POS = 14'd8191;

    logic        clk = 1'b0;
    logic        rst, en, mode, vld;
    logic [13:0] vc, ic;
    logic [15:0] cosv, sinv;
    logic        o_sigma, o_switch, o_valid, o_busy;
    logic [13:0] o_debug;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t pend_e;
    logic pend = 1'b0;
    int   busy_run = 0;
    int   last_busy_len = 0;

    hybrid_control_pipe dut (
        .i_clock (clk),
        .i_RESET (rst),
        .i_enable(en),
        .i_mode  (mode),
        .i_valid (vld),
        .i_vC    (vc),
        .i_iC    (ic),
        .i_cos   (cosv),
        .i_sin   (sinv),
        .o_sigma (o_sigma),
        .o_switch(o_switch),
        .o_valid (o_valid),
        .o_busy  (o_busy),
        .o_debug (o_debug)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [13:0] d, input logic sw, input logic sig);
        exp_t e;
        e.dbg = d;
        e.sw  = sw;
        e.sig = sig;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [13:0] v, input logic [13:0] i,
                        input logic [13:0] d, input logic sw, input logic sig);
        vc  = v;
        ic  = i;
        vld = 1'b1;
        push(d, sw, sig);
        tick();
        vld = 1'b0;
    endtask

    // Monitor: switch/sigma are checked the cycle after the matching decision.
    always @(negedge clk) begin : mon
        exp_t e;
        if (pend) begin
            check("switch", int'(o_switch), int'(pend_e.sw));
            check("sigma", int'(o_sigma), int'(pend_e.sig));
            pend = 1'b0;
        end else begin
            check("idle_switch", int'(o_switch), 0);
        end
        if (o_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: o_valid=1 with no decision expected (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check("debug", int'(o_debug), int'(e.dbg));
                pend_e = e;
                pend   = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (o_busy === 1'b1) begin
            busy_run++;
        end else begin
            if (busy_run != 0) last_busy_len = busy_run;
            busy_run = 0;
        end
    end

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        mode = 1'b0;
        vld  = 1'b0;
        vc   = 14'd0;
        ic   = 14'd0;
        cosv = 16'd16384;
        sinv = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sigma", int'(o_sigma), 1);
        check("rst_valid", int'(o_valid), 0);
        check("rst_debug", int'(o_debug), 0);
        check("rst_busy", int'(o_busy), 0);
        rst = 1'b0;
        en  = 1'b1;

        // Held valid: toggle, flush of two in-flight samples, dwell-blocked
        // re-toggle, then toggle at the first decision after lockout.
        for (int i = 0; i <= 20; i++) begin
            vld = 1'b1;
            if (i < 6) begin
                vc = 14'd0;
                ic = 14'd100;
            end else begin
                vc = 14'd0;
                ic = -14'sd100;
            end
            if (i == 0)                 push(DBG_NEG, 1'b1, 1'b0);
            else if (i >= 3 && i <= 5)  push(DBG_POS, 1'b0, 1'b0);
            else if (i >= 6 && i <= 15) push(DBG_NEG, 1'b0, 1'b0);
            else if (i == 16)           push(DBG_NEG, 1'b1, 1'b1);
            else if (i >= 19)           push(DBG_POS, 1'b0, 1'b1);
            tick();
        end
        vld = 1'b0;
        repeat (25) tick();
        check("busy_len_a", last_busy_len, 15);
        check("sigma_a", int'(o_sigma), 1);

        // Mode comparison with sigma = 1.
        mode = 1'b1;
        send(14'd0, -14'sd100, DBG_POS, 1'b0, 1'b1);
        repeat (6) tick();
        mode = 1'b0;
        send(14'd0, -14'sd100, DBG_POS, 1'b0, 1'b1);
        repeat (6) tick();
        send(14'd300, 14'd100, DBG_NEG, 1'b0, 1'b1);
        repeat (6) tick();
        mode = 1'b1;
        send(14'd300, 14'd100, DBG_NEG, 1'b1, 1'b0);
        repeat (6) tick();
        mode = 1'b0;
        repeat (20) tick();
        check("busy_len_b", last_busy_len, 15);
        check("sigma_b", int'(o_sigma), 0);

        // Enable low suppresses an otherwise valid toggle.
        en = 1'b0;
        send(14'd0, -14'sd100, DBG_NEG, 1'b0, 1'b0);
        repeat (6) tick();
        en = 1'b1;

        // Reset asserted in the toggle cycle wins.
        send(14'd0, -14'sd100, DBG_NEG, 1'b0, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_sigma", int'(o_sigma), 1);
        check("rst_mid_valid", int'(o_valid), 0);
        check("rst_mid_busy", int'(o_busy), 0);
        repeat (5) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
